// File: rtl/decade_timer_ctrl.sv
// decade_timer_ctrl: BCD up/down timer sequencer.
// A prescaler divides clk into count steps. A start/stop/clear/load FSM
// controls a chain of DIGITS decade counters with ripple carry/borrow.
// Terminal count is all-9s counting up, or all-0s counting down.
// Optional lap capture register is built when TIMER_LAP_EN is defined.
module decade_timer_ctrl #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                clear,
  input  logic                load,
  input  logic                d,
  input  logic [4*DIGITS-1:0] load_val,
`ifdef TIMER_LAP_EN
  input  logic                lap,
  output logic [4*DIGITS-1:0] lap_count,
`endif
  output logic [4*DIGITS-1:0] count,
  output logic [1:0]          state,
  output logic                busy,
  output logic                done
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [W-1:0]  ALL9 = {DIGITS{4'h9}};
  localparam logic [W-1:0]  ZERO = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_e;

  state_e         state_q;
  state_e         state_n;
  logic [W-1:0]   count_q;
  logic [PW-1:0]  presc_q;
  logic           dir_q;
  logic           done_q;

  logic           tick;
  logic           load_en;
  logic           start_en;
  logic           step_en;
  logic           terminal;
  logic [W-1:0]   step_val;
  logic [W-1:0]   load_clamped;
  logic [W-1:0]   wrap_val;

  // One BCD step of the whole chain: ripple carry (up) or borrow (down).
  function automatic logic [W-1:0] bcd_step(input logic [W-1:0] v, input logic down);
    logic [W-1:0] r;
    logic         c;
    logic [3:0]   dg;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      dg = v[4*i +: 4];
      if (c) begin
        if (down) begin
          if (dg == 4'd0) begin
            dg = 4'd9;
          end else begin
            dg = dg - 4'd1;
            c  = 1'b0;
          end
        end else begin
          if (dg == 4'd9) begin
            dg = 4'd0;
          end else begin
            dg = dg + 4'd1;
            c  = 1'b0;
          end
        end
      end
      r[4*i +: 4] = dg;
    end
    return r;
  endfunction

  // Any preset digit above 9 is forced to 9 so the count stays valid BCD.
  function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        r[4*i +: 4] = 4'd9;
      end
    end
    return r;
  endfunction

  assign tick         = (presc_q == PMAX);
  assign step_val     = bcd_step(count_q, dir_q);
  assign load_clamped = bcd_clamp(load_val);

  // Command decode: load is dead in RUN, stop beats start, load beats both.
  always_comb begin
    load_en  = load && (state_q != RUN);
    start_en = start && !stop && !load_en && (state_q != RUN);
    step_en  = (state_q == RUN) && !stop && tick;
    terminal = step_en && (dir_q ? (step_val == ZERO) : (step_val == ALL9));
    wrap_val = count_q;
    if (!d && (count_q == ALL9)) begin
      wrap_val = ZERO;
    end else if (d && (count_q == ZERO)) begin
      wrap_val = ALL9;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // FSM next-state logic; clear overrides every other command.
  always_comb begin
    state_n = state_q;
    if (clear) begin
      state_n = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_en) state_n = RUN;
        RUN: begin
          if (stop) begin
            state_n = PAUSE;
          end else if (terminal) begin
            state_n = DONE;
          end
        end
        PAUSE:   if (start_en) state_n = RUN;
        DONE:    if (start_en) state_n = RUN;
        default: state_n = IDLE;
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    busy  = (state_q == RUN);
    state = state_q;
  end

  // Count, prescaler, direction and done-pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      presc_q <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else if (clear) begin
      count_q <= '0;
      presc_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == RUN) begin
        if (!stop) begin
          if (tick) begin
            presc_q <= '0;
            count_q <= step_val;
            done_q  <= terminal;
          end else begin
            presc_q <= presc_q + PW'(1);
          end
        end
      end else if (load_en) begin
        count_q <= load_clamped;
      end else if (start_en) begin
        dir_q <= d;
        if (state_q == IDLE) begin
          presc_q <= '0;
        end else if (state_q == DONE) begin
          presc_q <= '0;
          count_q <= wrap_val;
        end
      end
    end
  end

`ifdef TIMER_LAP_EN
  // Lap snapshot of the running count.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      lap_count <= '0;
    end else if ((state_q == RUN) && lap) begin
      lap_count <= count_q;
    end
  end
`endif

  assign count = count_q;
  assign done  = done_q;

endmodule

// File: tb/tb_decade_timer_ctrl.sv
// tb_decade_timer_ctrl: table-driven check of decade_timer_ctrl
// (DIGITS=4, TICK_DIV=5) plus hand sequences for pause/resume,
// clear mid-run, reset mid-run and, with TIMER_LAP_EN, lap capture.
module tb_decade_timer_ctrl;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic        clear;
  logic        load;
  logic        d;
  logic [15:0] load_val;
  logic [15:0] count;
  logic [1:0]  state;
  logic        busy;
  logic        done;
`ifdef TIMER_LAP_EN
  logic        lap;
  logic [15:0] lap_count;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        start;
    logic        stop;
    logic        clear;
    logic        load;
    logic        d;
    logic [15:0] load_val;
    int          idle;
    logic [15:0] exp_count;
    logic [1:0]  exp_state;
    logic        exp_busy;
    logic        exp_done;
  } vec_t;

  vec_t vecs[28];
  vec_t v;

  decade_timer_ctrl #(.DIGITS(4), .TICK_DIV(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .load     (load),
    .d        (d),
    .load_val (load_val),
`ifdef TIMER_LAP_EN
    .lap      (lap),
    .lap_count(lap_count),
`endif
    .count    (count),
    .state    (state),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  function automatic vec_t mkVec(input logic s, input logic st, input logic cl,
                                 input logic ld, input logic dd, input logic [15:0] lv,
                                 input int idle, input logic [15:0] ec,
                                 input logic [1:0] es, input logic eb, input logic ed);
    vec_t r;
    r.start = s;  r.stop = st; r.clear = cl; r.load = ld; r.d = dd;
    r.load_val = lv; r.idle = idle;
    r.exp_count = ec; r.exp_state = es; r.exp_busy = eb; r.exp_done = ed;
    return r;
  endfunction

  // One pulse cycle with the vector's commands, then idle cycles; ends #1 after an edge.
  task automatic applyStimulus(input vec_t sv);
    start = sv.start; stop = sv.stop; clear = sv.clear; load = sv.load;
    d = sv.d; load_val = sv.load_val;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0;
    repeat (sv.idle) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] ec,
                             input logic [1:0] es, input logic eb, input logic ed);
    checks++;
    if (count !== ec) begin
      errors++;
      $display("[TB] FAIL %s count: got %h expected %h", tag, count, ec);
    end
    checks++;
    if (state !== es) begin
      errors++;
      $display("[TB] FAIL %s state: got %b expected %b", tag, state, es);
    end
    checks++;
    if (busy !== eb) begin
      errors++;
      $display("[TB] FAIL %s busy: got %b expected %b", tag, busy, eb);
    end
    checks++;
    if (done !== ed) begin
      errors++;
      $display("[TB] FAIL %s done: got %b expected %b", tag, done, ed);
    end
  endtask

  // Bounded wait for the count to reach a value.
  task automatic waitCount(input string tag, input logic [15:0] target, input int budget);
    int n = 0;
    while (count !== target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (count !== target) begin
      errors++;
      $display("[TB] FAIL %s timeout: count %h expected %h", tag, count, target);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected normal end");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Vector table: commands, idle cycles after the pulse, expected outputs.
    vecs[0]  = mkVec(1,0,0,0,0,16'h0000,4, 16'h0000,S_RUN,  1,0);
    vecs[1]  = mkVec(0,0,0,0,0,16'h0000,0, 16'h0001,S_RUN,  1,0);
    vecs[2]  = mkVec(0,1,0,0,0,16'h0000,0, 16'h0001,S_PAUSE,0,0);
    vecs[3]  = mkVec(0,0,0,1,0,16'h0009,0, 16'h0009,S_PAUSE,0,0);
    vecs[4]  = mkVec(1,0,0,0,0,16'h0000,4, 16'h0009,S_RUN,  1,0);
    vecs[5]  = mkVec(0,0,0,0,0,16'h0000,0, 16'h0010,S_RUN,  1,0);
    vecs[6]  = mkVec(0,1,0,0,0,16'h0000,0, 16'h0010,S_PAUSE,0,0);
    vecs[7]  = mkVec(0,0,0,1,0,16'h0099,0, 16'h0099,S_PAUSE,0,0);
    vecs[8]  = mkVec(1,0,0,0,0,16'h0000,4, 16'h0099,S_RUN,  1,0);
    vecs[9]  = mkVec(0,0,0,0,0,16'h0000,0, 16'h0100,S_RUN,  1,0);
    vecs[10] = mkVec(0,0,0,1,0,16'h1234,0, 16'h0100,S_RUN,  1,0);
    vecs[11] = mkVec(0,0,1,0,0,16'h0000,0, 16'h0000,S_IDLE, 0,0);
    vecs[12] = mkVec(1,0,0,1,0,16'hF0A2,0, 16'h9092,S_IDLE, 0,0);
    vecs[13] = mkVec(0,0,1,0,0,16'h0000,0, 16'h0000,S_IDLE, 0,0);
    vecs[14] = mkVec(1,1,0,0,0,16'h0000,0, 16'h0000,S_IDLE, 0,0);
    vecs[15] = mkVec(0,0,0,1,0,16'h0003,0, 16'h0003,S_IDLE, 0,0);
    vecs[16] = mkVec(1,0,0,0,1,16'h0000,4, 16'h0003,S_RUN,  1,0);
    vecs[17] = mkVec(0,0,0,0,1,16'h0000,0, 16'h0002,S_RUN,  1,0);
    vecs[18] = mkVec(0,0,0,0,0,16'h0000,3, 16'h0002,S_RUN,  1,0);
    vecs[19] = mkVec(0,0,0,0,0,16'h0000,0, 16'h0001,S_RUN,  1,0);
    vecs[20] = mkVec(0,0,0,0,0,16'h0000,3, 16'h0001,S_RUN,  1,0);
    vecs[21] = mkVec(0,0,0,0,0,16'h0000,0, 16'h0000,S_DONE, 0,1);
    vecs[22] = mkVec(0,0,0,0,0,16'h0000,0, 16'h0000,S_DONE, 0,0);
    vecs[23] = mkVec(0,0,0,0,0,16'h0000,19,16'h0000,S_DONE, 0,0);
    vecs[24] = mkVec(0,0,1,0,0,16'h0000,0, 16'h0000,S_IDLE, 0,0);
    vecs[25] = mkVec(1,0,0,0,1,16'h0000,4, 16'h0000,S_RUN,  1,0);
    vecs[26] = mkVec(0,0,0,0,1,16'h0000,0, 16'h9999,S_RUN,  1,0);
    vecs[27] = mkVec(0,0,1,0,0,16'h0000,0, 16'h0000,S_IDLE, 0,0);

    reset = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0;
    d = 1'b0; load_val = '0;
`ifdef TIMER_LAP_EN
    lap = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 16'h0000, S_IDLE, 1'b0, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 28; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_state,
                  vecs[i].exp_busy, vecs[i].exp_done);
    end

    // Clear mid-run at 0456: back to IDLE with zero count and no done pulse.
    applyStimulus(mkVec(0,0,0,1,0,16'h0455,0, 0,0,0,0));
    applyStimulus(mkVec(1,0,0,0,0,16'h0000,0, 0,0,0,0));
    waitCount("clear_wait", 16'h0456, 20);
    applyStimulus(mkVec(0,0,1,0,0,16'h0000,0, 0,0,0,0));
    checkOutput("clear_mid", 16'h0000, S_IDLE, 1'b0, 1'b0);
    applyStimulus(mkVec(0,0,0,0,0,16'h0000,3, 0,0,0,0));
    checkOutput("clear_after", 16'h0000, S_IDLE, 1'b0, 1'b0);

    // Pause two edges after a step; prescaler holds at 2, so resume steps 3 edges after start.
    applyStimulus(mkVec(0,0,0,1,0,16'h0455,0, 0,0,0,0));
    applyStimulus(mkVec(1,0,0,0,0,16'h0000,0, 0,0,0,0));
    waitCount("pause_wait", 16'h0456, 20);
    applyStimulus(mkVec(0,0,0,0,0,16'h0000,1, 0,0,0,0));
    applyStimulus(mkVec(0,1,0,0,0,16'h0000,0, 0,0,0,0));
    checkOutput("pause_entry", 16'h0456, S_PAUSE, 1'b0, 1'b0);
    applyStimulus(mkVec(0,0,0,0,0,16'h0000,4, 0,0,0,0));
    checkOutput("pause_frozen", 16'h0456, S_PAUSE, 1'b0, 1'b0);
    applyStimulus(mkVec(1,0,0,0,0,16'h0000,2, 0,0,0,0));
    checkOutput("resume_pre", 16'h0456, S_RUN, 1'b1, 1'b0);
    applyStimulus(mkVec(0,0,0,0,0,16'h0000,0, 0,0,0,0));
    checkOutput("resume_step", 16'h0457, S_RUN, 1'b1, 1'b0);

    // Reset exactly on the terminal edge of a down count: no done pulse.
    applyStimulus(mkVec(0,0,1,0,0,16'h0000,0, 0,0,0,0));
    applyStimulus(mkVec(0,0,0,1,0,16'h0001,0, 0,0,0,0));
    applyStimulus(mkVec(1,0,0,0,1,16'h0000,4, 0,0,0,0));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("reset_mid", 16'h0000, S_IDLE, 1'b0, 1'b0);
    @(posedge clk); #1;
    checkOutput("reset_after", 16'h0000, S_IDLE, 1'b0, 1'b0);

`ifdef TIMER_LAP_EN
    // Lap capture while running: count keeps going, lap_count holds the snapshot.
    applyStimulus(mkVec(0,0,0,1,0,16'h0041,0, 0,0,0,0));
    applyStimulus(mkVec(1,0,0,0,0,16'h0000,4, 0,0,0,0));
    applyStimulus(mkVec(0,0,0,0,0,16'h0000,0, 0,0,0,0));
    lap = 1'b1;
    @(posedge clk); #1;
    lap = 1'b0;
    checks++;
    if (lap_count !== 16'h0042) begin
      errors++;
      $display("[TB] FAIL lap_capture: got %h expected %h", lap_count, 16'h0042);
    end
    waitCount("lap_wait", 16'h0043, 20);
    checks++;
    if (lap_count !== 16'h0042) begin
      errors++;
      $display("[TB] FAIL lap_hold: got %h expected %h", lap_count, 16'h0042);
    end
    applyStimulus(mkVec(0,0,1,0,0,16'h0000,0, 0,0,0,0));
    checks++;
    if (lap_count !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL lap_clear: got %h expected %h", lap_count, 16'h0000);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
